// File: rtl/wptr_full_ctrl.sv
// Write-domain pointer/status controller for the async FIFO.
// Drives RAM address, Gray pointer to the synchronizer and full/level flags.
module wptr_full_ctrl #(
  parameter int ADDR_WIDTH = 6,
  parameter int AF_THRESH  = 60
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  winc,
  input  logic                  clr_ovf,
  input  logic [ADDR_WIDTH:0]   rptr_sync,
  output logic                  wen,
  output logic [ADDR_WIDTH-1:0] waddr,
  output logic [ADDR_WIDTH:0]   wptr,
  output logic                  wfull,
  output logic                  walmost_full,
  output logic [ADDR_WIDTH:0]   wlevel,
  output logic                  woverflow
);

  localparam int PW = ADDR_WIDTH + 1;
  localparam logic [PW-1:0] AF_T = PW'(AF_THRESH);

  logic [PW-1:0] wbin_q, wbin_d;
  logic [PW-1:0] wptr_q, wgray_d;
  logic [PW-1:0] lvl_q, lvl_d;
  logic [PW-1:0] rbin;
  logic [PW-1:0] full_cmp;
  logic          full_q, full_d;
  logic          af_q, af_d;
  logic          ovf_q, ovf_d;

  assign wen = winc & ~full_q;

  always_comb begin
    rbin = '0;
    rbin[PW-1] = rptr_sync[PW-1];
    for (int i = PW - 2; i >= 0; i--) begin
      rbin[i] = rbin[i+1] ^ rptr_sync[i];
    end
  end

  // Full when our next pointer sits exactly one lap ahead of the read pointer.
  assign full_cmp = {~rptr_sync[PW-1:PW-2], rptr_sync[PW-3:0]};

  always_comb begin
    wbin_d  = wbin_q + {{(PW-1){1'b0}}, wen};
    wgray_d = wbin_d ^ (wbin_d >> 1);
    lvl_d   = wbin_d - rbin;
    full_d  = (wgray_d == full_cmp);
    af_d    = (lvl_d >= AF_T);
    ovf_d   = (winc & full_q) | (ovf_q & ~clr_ovf);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wbin_q <= '0;
      wptr_q <= '0;
      lvl_q  <= '0;
      full_q <= 1'b0;
      af_q   <= 1'b0;
      ovf_q  <= 1'b0;
    end else begin
      wbin_q <= wbin_d;
      wptr_q <= wgray_d;
      lvl_q  <= lvl_d;
      full_q <= full_d;
      af_q   <= af_d;
      ovf_q  <= ovf_d;
    end
  end

  assign waddr        = wbin_q[ADDR_WIDTH-1:0];
  assign wptr         = wptr_q;
  assign wfull        = full_q;
  assign walmost_full = af_q;
  assign wlevel       = lvl_q;
  assign woverflow    = ovf_q;

endmodule

// File: tb/tb_wptr_full_ctrl.sv
// Directed bench for wptr_full_ctrl (ADDR_WIDTH=6, AF_THRESH=60).
// Covers reset, fill, overflow, un-full, wrap and mid-run reset.
module tb_wptr_full_ctrl;

  logic       clk = 1'b0;
  logic       clk_en = 1'b0;
  logic       rst_n;
  logic       winc;
  logic       clr_ovf;
  logic [6:0] rptr_sync;
  logic       wen;
  logic [5:0] waddr;
  logic [6:0] wptr;
  logic       wfull;
  logic       walmost_full;
  logic [6:0] wlevel;
  logic       woverflow;

  int n_chk = 0;
  int n_pass = 0;

  wptr_full_ctrl #(.ADDR_WIDTH(6), .AF_THRESH(60)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .winc         (winc),
    .clr_ovf      (clr_ovf),
    .rptr_sync    (rptr_sync),
    .wen          (wen),
    .waddr        (waddr),
    .wptr         (wptr),
    .wfull        (wfull),
    .walmost_full (walmost_full),
    .wlevel       (wlevel),
    .woverflow    (woverflow)
  );

  initial begin
    forever begin
      #5;
      if (clk_en) clk = ~clk;
    end
  end

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0;
    winc = 1'b0;
    clr_ovf = 1'b0;
    rptr_sync = 7'h00;
    #3;
    chk("rst_wptr", wptr, 7'h00);
    chk("rst_waddr", waddr, 6'd0);
    chk("rst_full", wfull, 1'b0);
    chk("rst_af", walmost_full, 1'b0);
    chk("rst_lvl", wlevel, 7'd0);
    chk("rst_ovf", woverflow, 1'b0);
    winc = 1'b1;
    #1;
    chk("rst_wen", wen, 1'b1);
    rst_n = 1'b1;
    #1;
    clk_en = 1'b1;

    // fill
    for (int i = 1; i <= 64; i++) begin
      step();
      if (i == 10) chk("fill_waddr10", waddr, 6'd10);
      if (i == 59) chk("fill_af59", walmost_full, 1'b0);
      if (i == 60) begin
        chk("fill_lvl60", wlevel, 7'd60);
        chk("fill_af60", walmost_full, 1'b1);
        chk("fill_full60", wfull, 1'b0);
      end
      if (i == 63) chk("fill_full63", wfull, 1'b0);
    end
    chk("fill_full", wfull, 1'b1);
    chk("fill_wptr", wptr, 7'h60);
    chk("fill_waddr", waddr, 6'd0);
    chk("fill_lvl", wlevel, 7'd64);
    chk("fill_wen", wen, 1'b0);

    // overflow
    step();
    chk("ovf_wptr", wptr, 7'h60);
    chk("ovf_set", woverflow, 1'b1);
    chk("ovf_lvl", wlevel, 7'd64);
    winc = 1'b0;
    clr_ovf = 1'b1;
    step();
    chk("ovf_clr", woverflow, 1'b0);
    winc = 1'b1;
    step();
    chk("ovf_setwins", woverflow, 1'b1);
    winc = 1'b0;
    clr_ovf = 1'b0;

    // un-full
    rptr_sync = 7'h01;
    step();
    chk("unf_full", wfull, 1'b0);
    chk("unf_lvl", wlevel, 7'd63);
    chk("unf_af", walmost_full, 1'b1);
    chk("unf_ovf_hold", woverflow, 1'b1);
    winc = 1'b1;
    #1;
    chk("unf_wen", wen, 1'b1);
    winc = 1'b0;

    // wrap with read pointer trailing by one
    rst_n = 1'b0;
    #1;
    rst_n = 1'b1;
    rptr_sync = 7'h00;
    winc = 1'b1;
    for (int i = 1; i <= 130; i++) begin
      rptr_sync = wptr;
      step();
      chk("wrap_full", wfull, 1'b0);
      chk("wrap_lvl", wlevel, 7'd1);
    end
    chk("wrap_wptr", wptr, 7'h03);
    chk("wrap_waddr", waddr, 6'd2);
    chk("wrap_ovf", woverflow, 1'b0);

    // reset mid-fill
    winc = 1'b0;
    rst_n = 1'b0;
    #1;
    rst_n = 1'b1;
    rptr_sync = 7'h00;
    winc = 1'b1;
    for (int i = 0; i < 10; i++) step();
    chk("mid_waddr10", waddr, 6'd10);
    winc = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_wptr", wptr, 7'h00);
    chk("mid_rst_waddr", waddr, 6'd0);
    chk("mid_rst_lvl", wlevel, 7'd0);
    chk("mid_rst_full", wfull, 1'b0);
    rst_n = 1'b1;
    winc = 1'b1;
    step();
    winc = 1'b0;
    chk("mid_waddr", waddr, 6'd1);
    chk("mid_wptr", wptr, 7'h01);
    chk("mid_lvl", wlevel, 7'd1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/wptr_full_ctrl.md
# wptr_full_ctrl

Write-domain pointer and status controller for the async FIFO. Accepts write requests, generates the binary RAM write address and the Gray-coded write pointer handed to the cross-domain pointer synchronizer, and consumes the read pointer already synchronized into the write domain. From these it produces registered full, almost-full, occupancy and sticky overflow indications. It sits between the write-side client and the memory/synchronizer stages.

## Interface
- ADDR_WIDTH, 6, RAM address width; depth DEPTH = 2**ADDR_WIDTH; pointers are ADDR_WIDTH+1 bits
- AF_THRESH, 60, occupancy at or above which walmost_full asserts (valid range 1..DEPTH)

- clk  input  1  write-domain clock, rising edge
- rst_n  input  1  asynchronous, active-low reset
- winc  input  1  write request from client
- clr_ovf  input  1  clear for sticky overflow flag
- rptr_sync  input  ADDR_WIDTH+1  Gray read pointer, already synchronized into clk domain
- wen  output  1  RAM write strobe, combinational: winc & ~wfull
- waddr  output  ADDR_WIDTH  binary RAM write address (low bits of binary write pointer)
- wptr  output  ADDR_WIDTH+1  registered Gray write pointer, to synchronizer
- wfull  output  1  registered full flag
- walmost_full  output  1  registered, wlevel >= AF_THRESH
- wlevel  output  ADDR_WIDTH+1  registered occupancy estimate, 0..DEPTH
- woverflow  output  1  sticky: write attempted while full

## Operation
- Internal state: wbin (ADDR_WIDTH+1 binary pointer), wptr, wfull, walmost_full, wlevel, woverflow.
- Accept: wen = winc & ~wfull. wbin_next = wbin + wen, modulo 2**(ADDR_WIDTH+1).
- wgray_next = wbin_next ^ (wbin_next >> 1); wptr <= wgray_next every edge.
- waddr = wbin[ADDR_WIDTH-1:0], driven from the register (no combinational path from winc).
- Full: wfull <= (wgray_next == {~rptr_sync[MSB:MSB-1], rptr_sync[MSB-2:0]}). Evaluated every edge, including edges with no write, so a read advance clears full.
- Level: rbin = Gray-to-binary(rptr_sync); wlevel <= (wbin_next - rbin) mod 2**(ADDR_WIDTH+1). Pessimistic (stale read pointer), never exceeds DEPTH.
- walmost_full <= (level_next >= AF_THRESH), same next value used for wlevel.
- Overflow: winc & wfull at an edge sets woverflow; pointer does not advance. clr_ovf clears it; set wins over clear in the same cycle.
- Wrap-around: wbin rolls from 2**(ADDR_WIDTH+1)-1 to 0 with no special handling; the Gray sequence stays single-bit-change across the wrap.
- rptr_sync treated as a plain registered input; no additional synchronization inside this block.

## Timing
- Reset (rst_n low, asynchronous, no clock required): wbin=0, wptr=0, waddr=0, wfull=0, walmost_full=0, wlevel=0, woverflow=0. wen follows winc during reset (wfull=0); downstream RAM is held by its own reset.
- Reset asserted mid-operation clears all state immediately; first accepted write after release lands at waddr 0.
- Write latency: write accepted at edge N appears in waddr/wptr/wlevel after edge N; wfull/walmost_full reflect that write after edge N (no extra cycle).
- Read-side effect: change on rptr_sync reflected in wfull/wlevel after the next edge.
- Simultaneous write and rptr_sync advance: both folded into one update; level unchanged, full cannot newly assert.

## Test plan
- Reset: drive rst_n low with clk stopped -> all registered outputs 0, wptr=0x00.
- Fill (ADDR_WIDTH=6, rptr_sync=0): winc high 64 cycles -> wlevel=60 and walmost_full=1 after 60th write; after 64th write wfull=1, wptr=0x60, waddr=0, wlevel=64; wen=0 next cycle.
- Overflow: keep winc high while full -> wptr holds 0x60, woverflow=1 after next edge; pulse clr_ovf with winc low -> woverflow=0; clr_ovf with winc high same cycle -> woverflow stays 1.
- Un-full: from full, set rptr_sync=0x01 (gray 1), winc low -> after next edge wfull=0, wlevel=63, walmost_full=1.
- Wrap: drive rptr_sync = wptr each cycle, 130 consecutive writes -> wbin wraps past 127, final wptr=0x03 (gray 2), wfull never asserts, wlevel=1 throughout.
- Reset mid-fill: after 10 writes assert rst_n between edges -> outputs 0 immediately; after release one write -> waddr=1, wptr=0x01.
